dcache_wb_ctrl: RTL and testbench

Direct-mapped, write-back, write-allocate data cache placed between the pipeline's MEM stage and a slow off-chip data memory. It serves 32-bit word loads/stores from the EX/MEM stage and stalls the pipeline on misses. It evicts dirty lines and refills whole 256-bit lines over a request/acknowledge handshake. On a hit it answers combinationally in the same cycle, so the MEM stage timing is unchanged.

---
 rtl/dcache_wb_ctrl.sv | 131 +++++++++++++
 tb/tb_dcache_wb_ctrl.sv | 215 +++++++++++++++++++++
 2 files changed

// File: rtl/dcache_wb_ctrl.sv
// Direct-mapped write-back, write-allocate data cache controller between the MEM stage
// and a slow line-wide memory; hits answer combinationally, misses stall the pipeline.
module dcache_wb_ctrl #(
  parameter int SETS  = 32,
  parameter int TAG_W = 22
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic [31:0]  cpu_addr_i,
  input  logic [31:0]  cpu_data_i,
  input  logic         cpu_MemRead_i,
  input  logic         cpu_MemWrite_i,
  output logic [31:0]  cpu_data_o,
  output logic         cpu_stall_o,
  output logic [31:0]  mem_addr_o,
  output logic [255:0] mem_data_o,
  output logic         mem_enable_o,
  output logic         mem_write_o,
  input  logic [255:0] mem_data_i,
  input  logic         mem_ack_i
);
  localparam int IDX_W = $clog2(SETS);

  typedef enum logic [1:0] {IDLE, WRITEBACK, ALLOCATE, REFILLED} state_t;

  state_t             state_q, state_d;
  logic [SETS-1:0]    valid_q, valid_d;
  logic [SETS-1:0]    dirty_q, dirty_d;
  logic [TAG_W-1:0]   tag_q  [SETS];
  logic [TAG_W-1:0]   tag_d  [SETS];
  logic [255:0]       data_q [SETS];
  logic [255:0]       data_d [SETS];
  logic [IDX_W-1:0]   idx_q, idx_d;
  logic [TAG_W-1:0]   tag_lat_q, tag_lat_d;

  logic [IDX_W-1:0]   req_idx;
  logic [TAG_W-1:0]   req_tag;
  logic [2:0]         req_word;
  logic               req_active, is_store, hit;
  logic               unused_addr_bits;

  assign req_idx          = cpu_addr_i[5 +: IDX_W];
  assign req_tag          = cpu_addr_i[31 -: TAG_W];
  assign req_word         = cpu_addr_i[4:2];
  assign unused_addr_bits = ^cpu_addr_i[1:0];
  assign req_active       = cpu_MemRead_i | cpu_MemWrite_i;
  assign is_store         = cpu_MemWrite_i;
  assign hit              = valid_q[req_idx] && (tag_q[req_idx] == req_tag);

  always_comb begin
    state_d      = state_q;
    valid_d      = valid_q;
    dirty_d      = dirty_q;
    tag_d        = tag_q;
    data_d       = data_q;
    idx_d        = idx_q;
    tag_lat_d    = tag_lat_q;
    cpu_data_o   = '0;
    cpu_stall_o  = 1'b0;
    mem_addr_o   = '0;
    mem_data_o   = '0;
    mem_enable_o = 1'b0;
    mem_write_o  = 1'b0;

    case (state_q)
      IDLE: begin
        if (req_active && hit) begin
          if (is_store) begin
            data_d[req_idx][{req_word, 5'b0} +: 32] = cpu_data_i;
            dirty_d[req_idx] = 1'b1;
          end else begin
            cpu_data_o = data_q[req_idx][{req_word, 5'b0} +: 32];
          end
        end else if (req_active) begin
          cpu_stall_o = 1'b1;
          idx_d       = req_idx;
          tag_lat_d   = req_tag;
          state_d     = (valid_q[req_idx] && dirty_q[req_idx]) ? WRITEBACK : ALLOCATE;
        end
      end
      WRITEBACK: begin
        cpu_stall_o  = req_active;
        mem_enable_o = 1'b1;
        mem_write_o  = 1'b1;
        mem_addr_o   = {tag_q[idx_q], idx_q, 5'b0};
        mem_data_o   = data_q[idx_q];
        if (mem_ack_i) state_d = ALLOCATE;
      end
      ALLOCATE: begin
        cpu_stall_o  = req_active;
        mem_enable_o = 1'b1;
        mem_addr_o   = {tag_lat_q, idx_q, 5'b0};
        // The line only changes on the ack edge, so an abandoned refill leaves it untouched.
        if (mem_ack_i) begin
          data_d[idx_q]  = mem_data_i;
          tag_d[idx_q]   = tag_lat_q;
          valid_d[idx_q] = 1'b1;
          dirty_d[idx_q] = 1'b0;
          state_d        = REFILLED;
        end
      end
      REFILLED: begin
        cpu_stall_o = req_active;
        state_d     = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q   <= IDLE;
      valid_q   <= '0;
      dirty_q   <= '0;
      idx_q     <= '0;
      tag_lat_q <= '0;
    end else begin
      state_q   <= state_d;
      valid_q   <= valid_d;
      dirty_q   <= dirty_d;
      idx_q     <= idx_d;
      tag_lat_q <= tag_lat_d;
    end
  end

  // Tag and data storage is qualified by the valid bits, so it needs no reset.
  always_ff @(posedge clk_i) begin
    tag_q  <= tag_d;
    data_q <= data_d;
  end
endmodule

// File: tb/tb_dcache_wb_ctrl.sv
// Directed self-checking bench for dcache_wb_ctrl: misses, hits, dirty evictions,
// write-allocate, reset during refill and stray acks.
module tb_dcache_wb_ctrl;
  logic         clk = 1'b0;
  logic         rst;
  logic [31:0]  cpu_addr;
  logic [31:0]  cpu_wdata;
  logic         cpu_rd;
  logic         cpu_wr;
  logic [31:0]  cpu_rdata;
  logic         cpu_stall;
  logic [31:0]  mem_addr;
  logic [255:0] mem_wdata;
  logic         mem_en;
  logic         mem_we;
  logic [255:0] mem_rdata;
  logic         mem_ack;

  int total = 0;
  int bad   = 0;

  dcache_wb_ctrl dut (
    .clk_i          (clk),
    .rst_i          (rst),
    .cpu_addr_i     (cpu_addr),
    .cpu_data_i     (cpu_wdata),
    .cpu_MemRead_i  (cpu_rd),
    .cpu_MemWrite_i (cpu_wr),
    .cpu_data_o     (cpu_rdata),
    .cpu_stall_o    (cpu_stall),
    .mem_addr_o     (mem_addr),
    .mem_data_o     (mem_wdata),
    .mem_enable_o   (mem_en),
    .mem_write_o    (mem_we),
    .mem_data_i     (mem_rdata),
    .mem_ack_i      (mem_ack)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [255:0] make_line(input logic [31:0] base);
    logic [255:0] l;
    for (int i = 0; i < 8; i++) l[i*32 +: 32] = base + i;
    return l;
  endfunction

  // Memory responder: acks the n-th cycle of each memory state and counts stalled cycles.
  task automatic run_req(input int wb_n, input int al_n, input logic [255:0] fill,
                         output int stalls, output int wb_seen,
                         output logic [31:0] wb_addr, output logic [255:0] wb_data,
                         output logic [31:0] al_addr);
    int al_seen;
    logic done;
    stalls = 0; wb_seen = 0; al_seen = 0; done = 1'b0;
    wb_addr = '0; wb_data = '0; al_addr = '0;
    for (int c = 0; c < 60 && !done; c++) begin
      #1;
      if (!cpu_stall) begin
        done = 1'b1;
      end else begin
        stalls++;
        mem_ack = 1'b0;
        if (mem_en && mem_we) begin
          wb_seen++;
          wb_addr = mem_addr;
          wb_data = mem_wdata;
          mem_ack = (wb_seen == wb_n);
        end else if (mem_en) begin
          al_seen++;
          al_addr   = mem_addr;
          mem_rdata = fill;
          mem_ack   = (al_seen == al_n);
        end
        @(posedge clk);
        #1;
        mem_ack = 1'b0;
      end
    end
    chk("miss_timeout", {255'b0, done}, 256'd1);
  endtask

  int           stalls, wb_seen;
  logic [31:0]  wb_addr, al_addr;
  logic [255:0] wb_data, exp_line;

  initial begin
    rst = 1'b1; cpu_addr = '0; cpu_wdata = '0; cpu_rd = 1'b0; cpu_wr = 1'b0;
    mem_rdata = '0; mem_ack = 1'b0;
    step(); step();
    rst = 1'b0;
    #1;
    chk("rst_mem_en",   {255'b0, mem_en},    256'd0);
    chk("rst_mem_we",   {255'b0, mem_we},    256'd0);
    chk("rst_mem_addr", {224'b0, mem_addr},  256'd0);
    chk("rst_stall",    {255'b0, cpu_stall}, 256'd0);
    chk("rst_rdata",    {224'b0, cpu_rdata}, 256'd0);

    // Clean load miss: 1 + 3 + 1 stall cycles.
    step();
    cpu_addr = 32'h40; cpu_rd = 1'b1;
    run_req(0, 3, make_line(32'h1000), stalls, wb_seen, wb_addr, wb_data, al_addr);
    chk("ld40_stalls",  stalls,  256'd5);
    chk("ld40_wb",      wb_seen, 256'd0);
    chk("ld40_al_addr", {224'b0, al_addr},   256'h40);
    chk("ld40_rdata",   {224'b0, cpu_rdata}, 256'h1000);

    // Store hit then reload.
    step();
    cpu_rd = 1'b0; cpu_wr = 1'b1; cpu_addr = 32'h44; cpu_wdata = 32'hDEADBEEF;
    #1;
    chk("st44_stall", {255'b0, cpu_stall}, 256'd0);
    step();
    cpu_wr = 1'b0; cpu_rd = 1'b1;
    #1;
    chk("ld44_stall", {255'b0, cpu_stall}, 256'd0);
    chk("ld44_rdata", {224'b0, cpu_rdata}, 256'hDEADBEEF);
    step();
    cpu_addr = 32'h48;
    #1;
    chk("ld48_rdata", {224'b0, cpu_rdata}, 256'h1002);

    // Dirty eviction: 1 + 2 (WB) + 1 (ALLOC) + 1 stall cycles.
    step();
    cpu_addr = 32'h440;
    run_req(2, 1, make_line(32'h2000), stalls, wb_seen, wb_addr, wb_data, al_addr);
    exp_line = make_line(32'h1000);
    exp_line[63:32] = 32'hDEADBEEF;
    chk("ld440_stalls",  stalls,  256'd5);
    chk("ld440_wb_cyc",  wb_seen, 256'd2);
    chk("ld440_wb_addr", {224'b0, wb_addr}, 256'h40);
    chk("ld440_wb_data", wb_data, exp_line);
    chk("ld440_al_addr", {224'b0, al_addr}, 256'h440);
    chk("ld440_rdata",   {224'b0, cpu_rdata}, 256'h2000);

    // Store miss with write-allocate, then a conflicting load evicts it.
    step();
    cpu_rd = 1'b0; cpu_wr = 1'b1; cpu_addr = 32'h88; cpu_wdata = 32'h12345678;
    run_req(0, 1, make_line(32'h3000), stalls, wb_seen, wb_addr, wb_data, al_addr);
    chk("st88_stalls",  stalls,  256'd3);
    chk("st88_wb",      wb_seen, 256'd0);
    chk("st88_al_addr", {224'b0, al_addr}, 256'h80);
    step();
    cpu_wr = 1'b0; cpu_rd = 1'b1;
    #1;
    chk("ld88_rdata", {224'b0, cpu_rdata}, 256'h12345678);
    step();
    cpu_addr = 32'h488;
    run_req(1, 2, make_line(32'h4000), stalls, wb_seen, wb_addr, wb_data, al_addr);
    exp_line = make_line(32'h3000);
    exp_line[95:64] = 32'h12345678;
    chk("ld488_stalls",  stalls,  256'd5);
    chk("ld488_wb_addr", {224'b0, wb_addr}, 256'h80);
    chk("ld488_wb_data", wb_data, exp_line);
    chk("ld488_al_addr", {224'b0, al_addr}, 256'h480);
    chk("ld488_rdata",   {224'b0, cpu_rdata}, 256'h4002);

    // Stray ack in IDLE must not disturb anything.
    step();
    cpu_rd = 1'b0; mem_ack = 1'b1; mem_rdata = {256{1'b1}};
    step();
    mem_ack = 1'b0;
    #1;
    chk("stray_mem_en", {255'b0, mem_en}, 256'd0);
    step();
    cpu_rd = 1'b1; cpu_addr = 32'h488;
    #1;
    chk("stray_ld488_stall", {255'b0, cpu_stall}, 256'd0);
    chk("stray_ld488_rdata", {224'b0, cpu_rdata}, 256'h4002);
    step();
    cpu_addr = 32'h444;
    #1;
    chk("stray_ld444_rdata", {224'b0, cpu_rdata}, 256'h2001);

    // Reset during ALLOCATE abandons the refill.
    step();
    cpu_addr = 32'h100;
    step();
    chk("mid_alloc_en", {255'b0, mem_en}, 256'd1);
    rst = 1'b1; cpu_rd = 1'b0;
    step();
    rst = 1'b0;
    #1;
    chk("post_rst_en",    {255'b0, mem_en},    256'd0);
    chk("post_rst_stall", {255'b0, cpu_stall}, 256'd0);
    step();
    cpu_rd = 1'b1; cpu_addr = 32'h488;
    #1;
    chk("post_rst_488_miss", {255'b0, cpu_stall}, 256'd1);
    cpu_addr = 32'h100;
    #1;
    chk("post_rst_100_miss", {255'b0, cpu_stall}, 256'd1);
    run_req(0, 1, make_line(32'h5000), stalls, wb_seen, wb_addr, wb_data, al_addr);
    chk("ld100_stalls", stalls, 256'd3);
    chk("ld100_rdata",  {224'b0, cpu_rdata}, 256'h5000);

    step();
    cpu_rd = 1'b0;
    step();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
